// File: rtl/uart_tx_fifo.sv
// UART 8N1 transmitter fed by a small write-side byte FIFO.
// Writes are fire-and-forget; full/empty/count report FIFO occupancy upstream.
module uart_tx_fifo #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [7:0]                    wr_data,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          busy,
    output logic                          tx
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   CNT_FULL  = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_t;

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_full;
    logic          r_empty;

    state_t        r_state;
    logic [CW-1:0] r_baud;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;
    logic          r_tx;
    logic          r_busy;

    logic          w_accept;
    logic          w_bit_end;
    logic          w_pop;
    logic [AW:0]   w_count_nxt;

    // Acceptance uses the registered full flag, so a pop on the same edge cannot rescue a write.
    assign w_accept  = wr_en && !r_full;
    assign w_bit_end = (r_baud == BAUD_LAST);
    assign w_pop     = (r_count != '0) &&
                       ((r_state == StIdle) || ((r_state == StStop) && w_bit_end));

    always_comb begin
        w_count_nxt = r_count;
        if (w_accept && !w_pop) begin
            w_count_nxt = r_count + 1'b1;
        end else if (!w_accept && w_pop) begin
            w_count_nxt = r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CNT_FULL);
            r_empty <= (w_count_nxt == '0);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= StIdle;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    r_tx <= 1'b1;
                    if (w_pop) begin
                        r_state <= StStart;
                        r_baud  <= '0;
                        r_shift <= r_mem[r_rd_ptr];
                        r_tx    <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                StStart: begin
                    if (w_bit_end) begin
                        r_baud    <= '0;
                        r_bit_idx <= '0;
                        r_state   <= StData;
                        r_tx      <= r_shift[0];
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                StData: begin
                    if (w_bit_end) begin
                        r_baud <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= StStop;
                            r_tx    <= 1'b1;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                            r_tx      <= r_shift[r_bit_idx + 3'd1];
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                StStop: begin
                    if (w_bit_end) begin
                        r_baud <= '0;
                        // Chain straight into the next start bit when data is waiting.
                        if (w_pop) begin
                            r_state <= StStart;
                            r_shift <= r_mem[r_rd_ptr];
                            r_tx    <= 1'b0;
                        end else begin
                            r_state <= StIdle;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_baud  <= '0;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign full  = r_full;
    assign empty = r_empty;
    assign count = r_count;
    assign busy  = r_busy;
    assign tx    = r_tx;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomised and directed bench for uart_tx_fifo: cycle-level frame/queue model plus a
// line receiver that decodes tx independently.
module tb_uart_tx_fifo;

    localparam int C = 4;
    localparam int D = 4;
    localparam int FRAME = 10 * C;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       full;
    logic       empty;
    logic [2:0] count;
    logic       busy;
    logic       tx;

    uart_tx_fifo #(
        .CLKS_PER_BIT(C),
        .FIFO_DEPTH  (D)
    ) u_dut (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (wr_en),
        .wr_data(wr_data),
        .full   (full),
        .empty  (empty),
        .count  (count),
        .busy   (busy),
        .tx     (tx)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     tag, obs, obs, exp, exp, $time);
        end
    endtask

    // Reference model: byte queue plus position within the current 10-bit frame.
    logic [7:0] m_q[$];
    logic [7:0] m_sent[$];
    int         m_pos = -1;
    logic [7:0] m_byte = 8'h00;

    function automatic int m_tx();
        int idx;
        if (m_pos < 0) return 1;
        idx = m_pos / C;
        if (idx == 0) return 0;
        if (idx == 9) return 1;
        return int'(m_byte[idx-1]);
    endfunction

    task automatic model_edge(input logic we, input logic [7:0] d);
        bit acc;
        acc = we && (m_q.size() < D);
        if ((m_pos < 0 || m_pos == FRAME - 1) && m_q.size() > 0) begin
            m_byte = m_q.pop_front();
            m_sent.push_back(m_byte);
            m_pos  = 0;
        end else if (m_pos == FRAME - 1) begin
            m_pos = -1;
        end else if (m_pos >= 0) begin
            m_pos++;
        end
        if (acc) m_q.push_back(d);
    endtask

    task automatic compare_all();
        check_val("tx", int'(tx), m_tx());
        check_val("busy", int'(busy), (m_pos >= 0) ? 1 : 0);
        check_val("count", int'(count), m_q.size());
        check_val("full", int'(full), (m_q.size() == D) ? 1 : 0);
        check_val("empty", int'(empty), (m_q.size() == 0) ? 1 : 0);
    endtask

    // Called at a falling edge; returns at the next falling edge after checking.
    task automatic step(input logic we, input logic [7:0] d);
        wr_en   = we;
        wr_data = d;
        @(posedge clk);
        model_edge(we, d);
        @(negedge clk);
        wr_en = 1'b0;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00);
    endtask

    task automatic do_reset(input int n);
        wr_en = 1'b0;
        rst   = 1'b0;
        #1;
        m_q.delete();
        m_pos = -1;
        check_val("rst_tx", int'(tx), 1);
        check_val("rst_busy", int'(busy), 0);
        check_val("rst_count", int'(count), 0);
        compare_all();
        repeat (n) @(negedge clk);
        rst = 1'b1;
        compare_all();
    endtask

    // Independent line receiver sampling mid-bit.
    int         rx_t = -1;
    logic [7:0] rx_b = 8'h00;
    logic [7:0] rx_q[$];

    always @(negedge clk) begin
        if (!rst) begin
            rx_t = -1;
        end else if (rx_t < 0) begin
            if (tx == 1'b0) rx_t = 0;
        end else begin
            rx_t++;
            for (int k = 0; k < 8; k++) begin
                if (rx_t == (k + 1) * C + C / 2) rx_b[k] = tx;
            end
            if (rx_t == 9 * C + C / 2 && tx == 1'b1) rx_q.push_back(rx_b);
            if (rx_t == FRAME - 1) rx_t = -1;
        end
    end

    task automatic check_rx(input string tag, input logic [7:0] exp[$]);
        check_val({tag, "_len"}, rx_q.size(), exp.size());
        for (int i = 0; i < exp.size() && i < rx_q.size(); i++) begin
            check_val($sformatf("%s_byte%0d", tag, i), int'(rx_q[i]), int'(exp[i]));
        end
    endtask

    task automatic wait_pos(input int target);
        int guard;
        guard = 0;
        while (m_pos != target && guard < 200) begin
            step(1'b0, 8'h00);
            guard++;
        end
        check_val("wait_pos", m_pos, target);
    endtask

    initial begin
        logic [7:0] exp[$];

        // Reset and quiet line
        @(negedge clk);
        do_reset(3);
        idle(50);
        check_val("quiet_rx", rx_q.size(), 0);

        // Single byte 0xA5
        rx_q.delete();
        step(1'b1, 8'hA5);
        check_val("a5_count_after_write", int'(count), 1);
        step(1'b0, 8'h00);
        check_val("a5_tx_start", int'(tx), 0);
        check_val("a5_count_popped", int'(count), 0);
        idle(45);
        exp = '{8'hA5};
        check_rx("a5", exp);

        // Burst overflow: 0x06 must be dropped
        rx_q.delete();
        for (int i = 1; i <= 6; i++) step(1'b1, 8'(i));
        check_val("burst_full", int'(full), 1);
        idle(5 * FRAME + 10);
        exp = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        check_rx("burst", exp);

        // Write on the STOP-end pop edge while full
        rx_q.delete();
        step(1'b1, 8'h10);
        for (int i = 0; i < 4; i++) step(1'b1, 8'h20 + 8'(i));
        check_val("stop_full", int'(full), 1);
        wait_pos(FRAME - 1);
        step(1'b1, 8'h77);
        check_val("stop_drop_count", int'(count), 3);
        check_val("stop_drop_full", int'(full), 0);
        idle(4 * FRAME + 10);
        exp = '{8'h10, 8'h20, 8'h21, 8'h22, 8'h23};
        check_rx("stop", exp);

        // Reset during DATA bit 3 with two bytes queued
        rx_q.delete();
        step(1'b1, 8'h11);
        step(1'b1, 8'h22);
        step(1'b1, 8'h33);
        wait_pos(4 * C + 1);
        check_val("mid_queued", int'(count), 2);
        #2;
        do_reset(2);
        idle(30);
        check_val("mid_no_frame", rx_q.size(), 0);
        step(1'b1, 8'h3C);
        idle(45);
        exp = '{8'h3C};
        check_rx("mid", exp);

        // Refill during STOP: no idle gap
        rx_q.delete();
        step(1'b1, 8'h99);
        wait_pos(9 * C + 1);
        step(1'b1, 8'h5A);
        wait_pos(FRAME - 1);
        step(1'b0, 8'h00);
        check_val("refill_start", int'(tx), 0);
        check_val("refill_busy", int'(busy), 1);
        idle(FRAME + 5);
        exp = '{8'h99, 8'h5A};
        check_rx("refill", exp);

        // Random traffic
        rx_q.delete();
        m_sent.delete();
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 9) < 2) ? 1'b1 : 1'b0, 8'($urandom));
        end
        idle(5 * FRAME + 10);
        check_rx("rand", m_sent);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

UART transmitter with a small write-side FIFO, the peripheral stage directly downstream of the pipeline's memory-mapped store path. The core issues single-cycle byte writes and does not wait for the serial line. The block buffers up to FIFO_DEPTH bytes and serialises each one as an 8N1 frame on `tx`. `full` is returned upstream so software can poll before writing.

## Interface
Parameters:
- CLKS_PER_BIT, default 868 — clock cycles per serial bit (100 MHz / 115200 baud); legal range ≥ 2.
- FIFO_DEPTH, default 4 — byte entries; power of two, ≥ 2.

Ports:
- clk  in  1  — single system clock; all state updates on its rising edge.
- rst  in  1  — reset, asynchronous, active-low; clears all state immediately.
- wr_en  in  1  — write request; sampled on the rising edge.
- wr_data  in  8  — byte to enqueue when wr_en is accepted.
- full  out  1  — FIFO holds FIFO_DEPTH bytes.
- empty  out  1  — FIFO holds 0 bytes.
- count  out  $clog2(FIFO_DEPTH)+1  — current FIFO occupancy.
- busy  out  1  — transmitter state ≠ IDLE.
- tx  out  1  — serial line, registered; idle high.

## Operation
- **Reset values:** tx = 1, busy = 0, count = 0, full = 0, empty = 1, state = IDLE, baud counter = 0, bit index = 0. FIFO contents are don't-care.
- **Write acceptance:**
  - A write is accepted on an edge where wr_en = 1 and full = 1 is not set. Use the registered full value before that edge.
  - An accepted write stores wr_data at the write pointer, then increments the pointer mod FIFO_DEPTH.
  - A write when full = 1 is dropped silently, even if a pop occurs on the same edge.
- **Pop:** removes the head into the shift register and increments the read pointer mod FIFO_DEPTH.
- **Count rule:** +1 on accept only, −1 on pop only, unchanged on accept+pop in the same edge. full and empty derive from the post-edge count.
- **State machine (states IDLE, START, DATA, STOP):**
  - IDLE: tx = 1. On an edge with count > 0: pop, go to START, clear the baud counter.
  - START: tx = 0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx = shift_reg[bit index], LSB first; each bit lasts CLKS_PER_BIT cycles. After bit 7 completes, go to STOP.
  - STOP: tx = 1 for CLKS_PER_BIT cycles. At its final cycle:
    - if count > 0: pop and go directly to START, with no idle gap;
    - else go to IDLE.
- **Baud counter:** counts 0..CLKS_PER_BIT−1. The bit ends when the counter reaches CLKS_PER_BIT−1; the counter then wraps to 0.
- **Mid-frame writes:** writes during a frame never disturb the frame in progress.
- **Reset mid-frame:** tx returns to 1 asynchronously, the frame is abandoned, and the FIFO is emptied. No partial frame is resumed.

## Timing
- **Latency:** a write accepted at edge N into an empty, idle block pops at edge N+1. tx falls after edge N+1.
- **Frame length:** exactly 10 × CLKS_PER_BIT cycles from the tx falling edge to the end of the stop bit.
- **Back-to-back frames:** period of exactly 10 × CLKS_PER_BIT cycles.
- **busy:** rises with the START entry edge. It falls on the edge that enters IDLE.
- **Status outputs:** full, empty and count are registered, valid one edge after the causing event. No combinational path from wr_en to any output.
- **tx:** registered and glitch-free.

## Test plan
All scenarios use CLKS_PER_BIT = 4 and FIFO_DEPTH = 4.

1. **Reset:** hold rst = 0 for 3 cycles, then release → tx = 1, busy = 0, count = 0, empty = 1, full = 0. No tx activity for 50 cycles.
2. **Single byte:** write 0xA5 at edge N → tx = 0 over cycles N+1..N+4. Then data bits 1,0,1,0,0,1,0,1 for 4 cycles each, then stop high for 4 cycles. busy falls at edge N+41; count returns to 0 at edge N+1.
3. **Burst overflow:** write 0x01..0x06 on six consecutive edges → the first five are accepted (one pops at the second edge); full = 1 after the fifth; 0x06 is dropped. Five contiguous frames (0x01..0x05) totalling 200 cycles, with no high gap between stop and start.
4. **Write at stop boundary:** FIFO full; write 0x77 on the same edge as the STOP-end pop → 0x77 is dropped and count goes 4→3. Four remaining frames are sent and 0x77 never appears.
5. **Reset mid-frame:** assert rst during DATA bit 3 with 2 bytes queued → tx = 1 immediately, count = 0, busy = 0. After release, nothing is sent until a new write of 0x3C, which produces one correct frame.
6. **Refill during STOP:** single frame in flight; write 0x5A during the STOP bit → the next start bit begins on the cycle after the stop bit, with no idle cycle, and 0x5A is sent correctly.
